// File: rtl/pc_alu_pkg.sv
// Shared constants for the RV32I PC/ALU execution slice: datapath width,
// 4-bit ALU operation codes and the main-control alu_op classes.
package pc_alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

endpackage

// File: rtl/pc_alu_core_unit.sv
// Combinational XLEN-bit ALU with zero flag; codes outside the defined
// set yield a zero result.
module pc_alu_unit #(
    parameter int XLEN = pc_alu_pkg::XLEN
) (
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] alu_result,
    output logic            zero
);
    import pc_alu_pkg::*;

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]         shamt;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign shamt = operand_b[SHW-1:0];
    assign a_s   = operand_a;
    assign b_s   = operand_b;

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_AND:  alu_result = operand_a & operand_b;
            ALU_OR:   alu_result = operand_a | operand_b;
            ALU_ADD:  alu_result = operand_a + operand_b;
            ALU_XOR:  alu_result = operand_a ^ operand_b;
            ALU_SLL:  alu_result = operand_a << shamt;
            ALU_SRL:  alu_result = operand_a >> shamt;
            ALU_SUB:  alu_result = operand_a - operand_b;
            ALU_SRA:  alu_result = a_s >>> shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

endmodule

// File: rtl/pc_alu_core.sv
// RV32I execution slice: PC register with pc+4, ALU-control decoder and
// the ALU itself. Next-PC selection lives outside this block.
module pc_alu_core #(
    parameter int                          XLEN     = pc_alu_pkg::XLEN,
    parameter logic [pc_alu_pkg::XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_result,
    output logic            zero
);
    import pc_alu_pkg::*;

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    always_comb begin
        pc_d = next_pc;
        if (!reset) begin
            pc_d = XLEN'(RESET_PC);
        end
    end

    always_ff @(posedge clock) begin
        pc_q <= pc_d;
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + XLEN'(4);

    // ADDI has no subtract form, so funct7_5 only selects SUB for R-type.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_MEM: alu_ctrl = ALU_ADD;
            ALUOP_BR:  alu_ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: alu_ctrl = (alu_op == ALUOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

    pc_alu_unit #(
        .XLEN (XLEN)
    ) u_alu (
        .alu_ctrl   (alu_ctrl),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_result (alu_result),
        .zero       (zero)
    );

endmodule

// File: tb/tb_pc_alu_core.sv
// Scoreboard bench for pc_alu_core: driver pushes model expectations,
// monitor pops and compares on the falling edge.
module tb_pc_alu_core;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic [31:0] pc, pc_plus4;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0;
    logic [31:0] operand_a = 32'h0;
    logic [31:0] operand_b = 32'h0;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;

    pc_alu_core dut (
        .clock      (clock),
        .reset      (reset),
        .next_pc    (next_pc),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .zero       (zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model state: what reset/next_pc looked like at the last edge.
    logic        prev_rst_n = 1'b0;
    logic [31:0] prev_npc   = 32'h0;

    function automatic logic [3:0] model_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic f7);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        case (f3)
            3'd0: return (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
            3'd1: return 4'b0100;
            3'd2: return 4'b1000;
            3'd3: return 4'b1001;
            3'd4: return 4'b0011;
            3'd5: return f7 ? 4'b0111 : 4'b0101;
            3'd6: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            4'b0011: return a ^ b;
            4'b0100: return 32'(longint'(a) * (longint'(1) << sh));
            4'b0101: return 32'(longint'(a) / (longint'(1) << sh));
            4'b0110: return 32'(longint'(a) - longint'(b) + 64'h1_0000_0000);
            4'b0111: return 32'(sa >>> sh);
            4'b1000: return (sa < sb) ? 32'd1 : 32'd0;
            4'b1001: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s [%s]: got %h, required %h", name, tag, act, req);
    endtask

    // One cycle: the edge consumes the previously driven reset/next_pc,
    // then new inputs are applied and the expected outputs queued.
    task automatic drive(input string tag, input logic rst_n, input logic [31:0] npc,
                         input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] mpc;
        @(posedge clock);
        mpc = prev_rst_n ? prev_npc : 32'h0;
        #1;
        reset = rst_n; next_pc = npc;
        alu_op = op; funct3 = f3; funct7_5 = f7; operand_a = a; operand_b = b;
        prev_rst_n = rst_n; prev_npc = npc;
        e.pc   = mpc;
        e.pc4  = 32'((longint'(mpc) + 4) % 64'h1_0000_0000);
        e.ctrl = model_ctrl(op, f3, f7);
        e.res  = model_res(e.ctrl, a, b);
        e.z    = (e.res == 32'd0);
        e.tag  = tag;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",         e.tag, pc,                 e.pc);
                chk("pc_plus4",   e.tag, pc_plus4,           e.pc4);
                chk("alu_ctrl",   e.tag, {28'h0, alu_ctrl},  {28'h0, e.ctrl});
                chk("alu_result", e.tag, alu_result,         e.res);
                chk("zero",       e.tag, {31'h0, zero},      {31'h0, e.z});
            end
        end
    end

    initial begin : driver
        // Reset held for three edges, then load and mid-run reset.
        drive("rst0", 1'b0, 32'h40, 2'b00, 3'd0, 1'b0, 32'd100, 32'hFFFF_FFFC);
        drive("rst1", 1'b0, 32'h40, 2'b01, 3'd0, 1'b0, 32'd7, 32'd7);
        drive("rst2", 1'b0, 32'h40, 2'b01, 3'd0, 1'b0, 32'd7, 32'd5);
        drive("load", 1'b1, 32'h40, 2'b00, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        drive("ld2",  1'b1, 32'h80, 2'b10, 3'd7, 1'b0, 32'hF000_000F, 32'd4);
        drive("midr", 1'b0, 32'h1234, 2'b10, 3'd6, 1'b0, 32'hF000_000F, 32'd4);
        drive("wrap", 1'b1, 32'hFFFF_FFFC, 2'b10, 3'd4, 1'b0, 32'hF000_000F, 32'd4);
        drive("r_sll", 1'b1, 32'h100, 2'b10, 3'd1, 1'b0, 32'hF000_000F, 32'd4);
        drive("r_srl", 1'b1, 32'h104, 2'b10, 3'd5, 1'b0, 32'hF000_000F, 32'd4);
        drive("r_sra", 1'b1, 32'h108, 2'b10, 3'd5, 1'b1, 32'hF000_000F, 32'd4);
        drive("r_sub", 1'b1, 32'h10C, 2'b10, 3'd0, 1'b1, 32'hF000_000F, 32'd4);
        drive("slt",   1'b1, 32'h110, 2'b10, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1);
        drive("sltu",  1'b1, 32'h114, 2'b10, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1);
        drive("addi",  1'b1, 32'h118, 2'b11, 3'd0, 1'b1, 32'd10, 32'd3);
        drive("rsub",  1'b1, 32'h11C, 2'b10, 3'd0, 1'b1, 32'd10, 32'd3);
        drive("srai",  1'b1, 32'h120, 2'b11, 3'd5, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        drive("srli",  1'b1, 32'h124, 2'b11, 3'd5, 1'b0, 32'h8000_0000, 32'h0000_0021);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            drive("rand", ($urandom_range(0, 15) != 0), $urandom(),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), a, b);
        end
        @(posedge clock);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
